idex_operand_stage: RTL and testbench

IDEX_OPERAND_STAGE -- requirements
Module: idex_operand_stage

---
 rtl/idex_operand_stage.sv | 129 ++++++++++++
 tb/tb_idex_operand_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/idex_operand_stage.sv
// idex_operand_stage: ID/EX pipeline register with load-use stall, flush bubbles and EX operand forwarding
//   clk, rst_n             clock, asynchronous active-low reset
//   i_id_*                 decoded instruction fields from ID
//   i_exm_*, i_wb_*        EX/MEM and MEM/WB forwarding sources
//   i_flush                squash the instruction entering EX
//   o_alu_a/b/S/Cin        alu32 operands and controls (OR of zeros while EX is empty)
//   o_ex_valid/rd/regwrite/memread  registered EX-stage control
//   o_stall_out            combinational hold request for PC and IF/ID
//   o_bubble_cnt           saturating count of stall bubbles
module idex_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic [4:0]  i_id_rd,
  input  logic [31:0] i_id_rdata1,
  input  logic [31:0] i_id_rdata2,
  input  logic [31:0] i_id_imm,
  input  logic        i_id_use_imm,
  input  logic [2:0]  i_id_S,
  input  logic        i_id_regwrite,
  input  logic        i_id_memread,
  input  logic [4:0]  i_exm_rd,
  input  logic        i_exm_regwrite,
  input  logic [31:0] i_exm_result,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_regwrite,
  input  logic [31:0] i_wb_data,
  input  logic        i_flush,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [2:0]  o_alu_S,
  output logic        o_alu_Cin,
  output logic        o_ex_valid,
  output logic [4:0]  o_ex_rd,
  output logic        o_ex_regwrite,
  output logic        o_ex_memread,
  output logic        o_stall_out,
  output logic [15:0] o_bubble_cnt
);
  logic        r_valid;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic [31:0] r_rdata1;
  logic [31:0] r_rdata2;
  logic [31:0] r_imm;
  logic        r_use_imm;
  logic [2:0]  r_s;
  logic        r_regwrite;
  logic        r_memread;
  logic [15:0] r_bubble_cnt;
  logic        w_load_in_ex;
  logic        w_dep;
  logic        w_bubble;
  logic        w_exm_ok;
  logic        w_wb_ok;
  logic [31:0] w_fwd_a;
  logic [31:0] w_fwd_b;
  assign w_load_in_ex = r_valid && r_memread && r_rd != 5'd0;
  // rs2 only matters when B really reads the register file
  assign w_dep        = i_id_rs1 == r_rd || (i_id_rs2 == r_rd && !i_id_use_imm);
  assign o_stall_out  = w_load_in_ex && i_id_valid && w_dep && !i_flush;
  assign w_bubble     = o_stall_out || i_flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm      <= '0;
      r_use_imm  <= 1'b0;
      r_s        <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm      <= '0;
      r_use_imm  <= 1'b0;
      r_s        <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
    end else begin
      r_valid    <= i_id_valid;
      r_rs1      <= i_id_rs1;
      r_rs2      <= i_id_rs2;
      r_rd       <= i_id_rd;
      r_rdata1   <= i_id_rdata1;
      r_rdata2   <= i_id_rdata2;
      r_imm      <= i_id_imm;
      r_use_imm  <= i_id_use_imm;
      r_s        <= i_id_S;
      r_regwrite <= i_id_regwrite;
      r_memread  <= i_id_memread;
    end
  end
  // flush bubbles are not counted, only those caused by a load-use stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bubble_cnt <= '0;
    else if (o_stall_out && r_bubble_cnt != 16'hFFFF) r_bubble_cnt <= r_bubble_cnt + 16'd1;
  end
  // r0 is hardwired to zero, so it is never a forwarding source
  assign w_exm_ok = i_exm_regwrite && i_exm_rd != 5'd0;
  assign w_wb_ok  = i_wb_regwrite && i_wb_rd != 5'd0;
  always_comb begin
    w_fwd_a = (w_exm_ok && i_exm_rd == r_rs1) ? i_exm_result :
              (w_wb_ok && i_wb_rd == r_rs1)   ? i_wb_data    : r_rdata1;
    w_fwd_b = (w_exm_ok && i_exm_rd == r_rs2) ? i_exm_result :
              (w_wb_ok && i_wb_rd == r_rs2)   ? i_wb_data    : r_rdata2;
  end
  // an empty EX stage presents 0 | 0 so the ALU result is 0
  assign o_alu_a       = r_valid ? w_fwd_a : 32'd0;
  assign o_alu_b       = r_valid ? (r_use_imm ? r_imm : w_fwd_b) : 32'd0;
  assign o_alu_S       = r_valid ? r_s : 3'b100;
  assign o_alu_Cin     = r_valid && r_s == 3'b011;
  assign o_ex_valid    = r_valid;
  assign o_ex_rd       = r_rd;
  assign o_ex_regwrite = r_regwrite;
  assign o_ex_memread  = r_memread;
  assign o_bubble_cnt  = r_bubble_cnt;
endmodule

// File: tb/tb_idex_operand_stage.sv
// tb_idex_operand_stage: directed vector table, hand sequences and randomized model check for idex_operand_stage
module tb_idex_operand_stage;
  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        use_imm;
    logic [2:0]  s;
    logic        rw, mr;
    logic [4:0]  exm_rd;
    logic        exm_rw;
    logic [31:0] exm_res;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic [31:0] wb_data;
    logic        flush;
  } in_t;
  typedef struct {
    logic        st, vl;
    logic [31:0] a, b;
    logic [2:0]  s;
    logic        cin;
    logic [15:0] cnt;
  } ex_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_id_valid, i_id_use_imm, i_id_regwrite, i_id_memread;
  logic [4:0] i_id_rs1, i_id_rs2, i_id_rd, i_exm_rd, i_wb_rd;
  logic [31:0] i_id_rdata1, i_id_rdata2, i_id_imm, i_exm_result, i_wb_data;
  logic [2:0] i_id_S;
  logic i_exm_regwrite, i_wb_regwrite, i_flush;
  logic [31:0] o_alu_a, o_alu_b;
  logic [2:0] o_alu_S;
  logic o_alu_Cin, o_ex_valid, o_ex_regwrite, o_ex_memread, o_stall_out;
  logic [4:0] o_ex_rd;
  logic [15:0] o_bubble_cnt;
  int n_run = 0;
  int n_fail = 0;
  in_t m;
  logic [15:0] m_cnt;
  logic a_st, e_st;
  always #5 clk = ~clk;
  idex_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_valid(i_id_valid), .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2), .i_id_rd(i_id_rd),
    .i_id_rdata1(i_id_rdata1), .i_id_rdata2(i_id_rdata2), .i_id_imm(i_id_imm),
    .i_id_use_imm(i_id_use_imm), .i_id_S(i_id_S), .i_id_regwrite(i_id_regwrite),
    .i_id_memread(i_id_memread), .i_exm_rd(i_exm_rd), .i_exm_regwrite(i_exm_regwrite),
    .i_exm_result(i_exm_result), .i_wb_rd(i_wb_rd), .i_wb_regwrite(i_wb_regwrite),
    .i_wb_data(i_wb_data), .i_flush(i_flush),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_S(o_alu_S), .o_alu_Cin(o_alu_Cin),
    .o_ex_valid(o_ex_valid), .o_ex_rd(o_ex_rd), .o_ex_regwrite(o_ex_regwrite),
    .o_ex_memread(o_ex_memread), .o_stall_out(o_stall_out), .o_bubble_cnt(o_bubble_cnt)
  );
  function automatic in_t mk(input logic vl, input logic [4:0] r1, r2, rd,
                             input logic [31:0] d1, d2, imm, input logic ui,
                             input logic [2:0] s, input logic rw, mr);
    in_t v;
    v = '{default: '0};
    v.valid = vl; v.rs1 = r1; v.rs2 = r2; v.rd = rd;
    v.d1 = d1; v.d2 = d2; v.imm = imm; v.use_imm = ui;
    v.s = s; v.rw = rw; v.mr = mr;
    return v;
  endfunction
  function automatic ex_t ex(input logic st, vl, input logic [31:0] a, b,
                             input logic [2:0] s, input logic cin, input logic [15:0] cnt);
    ex_t e;
    e.st = st; e.vl = vl; e.a = a; e.b = b; e.s = s; e.cin = cin; e.cnt = cnt;
    return e;
  endfunction
  task automatic drive(input in_t v);
    i_id_valid = v.valid; i_id_rs1 = v.rs1; i_id_rs2 = v.rs2; i_id_rd = v.rd;
    i_id_rdata1 = v.d1; i_id_rdata2 = v.d2; i_id_imm = v.imm; i_id_use_imm = v.use_imm;
    i_id_S = v.s; i_id_regwrite = v.rw; i_id_memread = v.mr;
    i_exm_rd = v.exm_rd; i_exm_regwrite = v.exm_rw; i_exm_result = v.exm_res;
    i_wb_rd = v.wb_rd; i_wb_regwrite = v.wb_rw; i_wb_data = v.wb_data; i_flush = v.flush;
  endtask
  // Reference model: the instruction sitting in EX plus the bubble counter.
  function automatic logic m_stall(input in_t v);
    if (!(m.valid && m.mr && m.rd != 0) || !v.valid || v.flush) return 1'b0;
    return v.rs1 == m.rd || (!v.use_imm && v.rs2 == m.rd);
  endfunction
  function automatic logic [31:0] m_src(input in_t v, input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 0) return rf;
    if (v.exm_rw && v.exm_rd == rs) return v.exm_res;
    if (v.wb_rw && v.wb_rd == rs) return v.wb_data;
    return rf;
  endfunction
  function automatic ex_t m_out(input in_t v);
    if (!m.valid) return ex(e_st, 1'b0, 0, 0, 3'b100, 1'b0, m_cnt);
    return ex(e_st, 1'b1, m_src(v, m.rs1, m.d1), m.use_imm ? m.imm : m_src(v, m.rs2, m.d2),
              m.s, m.s == 3'b011, m_cnt);
  endfunction
  task automatic m_edge(input in_t v);
    if (e_st || v.flush) m = '{default: '0};
    else m = v;
    if (e_st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask
  task automatic cyc(input in_t v);
    @(negedge clk);
    drive(v);
    #1;
    a_st = o_stall_out;
    e_st = m_stall(v);
    @(posedge clk);
    m_edge(v);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, want);
    end
  endtask
  task automatic chk_ex(input string p, input ex_t e);
    chk({p, " stall"}, {31'd0, a_st}, {31'd0, e.st});
    chk({p, " ex_valid"}, {31'd0, o_ex_valid}, {31'd0, e.vl});
    chk({p, " alu_a"}, o_alu_a, e.a);
    chk({p, " alu_b"}, o_alu_b, e.b);
    chk({p, " alu_S"}, {29'd0, o_alu_S}, {29'd0, e.s});
    chk({p, " alu_Cin"}, {31'd0, o_alu_Cin}, {31'd0, e.cin});
    chk({p, " bubble_cnt"}, {16'd0, o_bubble_cnt}, {16'd0, e.cnt});
  endtask
  function automatic in_t rnd();
    in_t v;
    v = mk($urandom_range(7) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
           5'($urandom_range(3)), $urandom, $urandom, $urandom, 1'($urandom_range(1)),
           3'($urandom_range(7)), 1'($urandom_range(1)), $urandom_range(2) == 0);
    v.exm_rd = 5'($urandom_range(3)); v.exm_rw = 1'($urandom_range(1)); v.exm_res = $urandom;
    v.wb_rd = 5'($urandom_range(3)); v.wb_rw = 1'($urandom_range(1)); v.wb_data = $urandom;
    v.flush = $urandom_range(9) == 0;
    return v;
  endfunction
  initial begin
    in_t vi[11];
    ex_t ve[11];
    in_t ld, dep, v;
    ex_t e;
    m = '{default: '0};
    m_cnt = 0;
    drive(mk(1, 7, 7, 7, 32'h1234, 32'h5678, 32'h9, 0, 3'b011, 1, 1));
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset ex_valid", {31'd0, o_ex_valid}, 0);
    chk("reset alu_a", o_alu_a, 0);
    chk("reset alu_b", o_alu_b, 0);
    chk("reset alu_S", {29'd0, o_alu_S}, 32'd4);
    chk("reset alu_Cin", {31'd0, o_alu_Cin}, 0);
    chk("reset stall", {31'd0, o_stall_out}, 0);
    chk("reset bubble_cnt", {16'd0, o_bubble_cnt}, 0);
    chk("reset ex_rd", {27'd0, o_ex_rd}, 0);
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    ld  = mk(1, 1, 2, 7, 32'h100, 32'h4, 32'h4, 1, 3'b010, 1, 1);
    dep = mk(1, 3, 7, 8, 32'h5, 32'h6, 32'h0, 0, 3'b010, 1, 0);
    vi[0] = mk(1, 1, 2, 3, 32'h31312020, 32'h33112200, 0, 0, 3'b011, 1, 0);
    ve[0] = ex(0, 1, 32'h31312020, 32'h33112200, 3'b011, 1, 0);
    vi[1] = mk(1, 5, 6, 4, 32'h11111111, 32'h22222222, 0, 0, 3'b000, 1, 0);
    vi[1].exm_rd = 5; vi[1].exm_rw = 1; vi[1].exm_res = 32'hAAAA0000;
    vi[1].wb_rd = 5; vi[1].wb_rw = 1; vi[1].wb_data = 32'h5555FFFF;
    ve[1] = ex(0, 1, 32'hAAAA0000, 32'h22222222, 3'b000, 0, 0);
    vi[2] = mk(1, 8, 9, 10, 32'h8, 32'h9, 0, 0, 3'b001, 1, 0);
    vi[2].exm_rd = 8; vi[2].exm_rw = 0; vi[2].exm_res = 32'hDEAD;
    vi[2].wb_rd = 9; vi[2].wb_rw = 1; vi[2].wb_data = 32'h12345678;
    ve[2] = ex(0, 1, 32'h8, 32'h12345678, 3'b001, 0, 0);
    vi[3] = mk(1, 0, 0, 11, 0, 0, 32'h10, 1, 3'b010, 1, 0);
    vi[3].exm_rd = 0; vi[3].exm_rw = 1; vi[3].exm_res = 32'hFFFFFFFF;
    vi[3].wb_rd = 0; vi[3].wb_rw = 1; vi[3].wb_data = 32'hFFFFFFFF;
    ve[3] = ex(0, 1, 0, 32'h10, 3'b010, 0, 0);
    vi[4] = ld;  ve[4] = ex(0, 1, 32'h100, 32'h4, 3'b010, 0, 0);
    vi[5] = dep; ve[5] = ex(1, 0, 0, 0, 3'b100, 0, 1);
    vi[6] = dep; vi[6].wb_rd = 7; vi[6].wb_rw = 1; vi[6].wb_data = 32'h77;
    ve[6] = ex(0, 1, 32'h5, 32'h77, 3'b010, 0, 1);
    vi[7] = ld;  ve[7] = ex(0, 1, 32'h100, 32'h4, 3'b010, 0, 1);
    vi[8] = dep; vi[8].flush = 1;
    ve[8] = ex(0, 0, 0, 0, 3'b100, 0, 1);
    vi[9] = ld;  ve[9] = ex(0, 1, 32'h100, 32'h4, 3'b010, 0, 1);
    vi[10] = mk(1, 3, 7, 8, 32'h5, 32'h6, 32'h40, 1, 3'b010, 1, 0);
    ve[10] = ex(0, 1, 32'h5, 32'h40, 3'b010, 0, 1);
    for (int i = 0; i < 11; i++) begin
      cyc(vi[i]);
      chk_ex($sformatf("vec%0d", i), ve[i]);
    end
    cyc(ld);
    force dut.r_bubble_cnt = 16'hFFFF;
    #1;
    release dut.r_bubble_cnt;
    m_cnt = 16'hFFFF;
    cyc(dep);
    chk("sat stall", {31'd0, a_st}, 1);
    chk("sat bubble_cnt", {16'd0, o_bubble_cnt}, 32'hFFFF);
    chk("sat ex_valid", {31'd0, o_ex_valid}, 0);
    cyc(ld);
    @(negedge clk);
    drive(dep);
    #1;
    chk("midstall stall", {31'd0, o_stall_out}, 1);
    rst_n = 1'b0;
    #1;
    chk("async ex_valid", {31'd0, o_ex_valid}, 0);
    chk("async alu_a", o_alu_a, 0);
    chk("async alu_S", {29'd0, o_alu_S}, 32'd4);
    chk("async stall", {31'd0, o_stall_out}, 0);
    chk("async bubble_cnt", {16'd0, o_bubble_cnt}, 0);
    rst_n = 1'b1;
    m = '{default: '0};
    m_cnt = 0;
    e_st = m_stall(dep);
    @(posedge clk);
    m_edge(dep);
    #1;
    chk("post-reset ex_valid", {31'd0, o_ex_valid}, 1);
    chk("post-reset alu_a", o_alu_a, 32'h5);
    chk("post-reset alu_b", o_alu_b, 32'h6);
    chk("post-reset ex_rd", {27'd0, o_ex_rd}, 32'd8);
    for (int i = 0; i < 400; i++) begin
      v = rnd();
      cyc(v);
      e = m_out(v);
      chk_ex($sformatf("rnd%0d", i), e);
      chk($sformatf("rnd%0d ex_rd", i), {27'd0, o_ex_rd}, {27'd0, m.rd});
      chk($sformatf("rnd%0d ex_regwrite", i), {31'd0, o_ex_regwrite}, {31'd0, m.rw});
      chk($sformatf("rnd%0d ex_memread", i), {31'd0, o_ex_memread}, {31'd0, m.mr});
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
